// File: rtl/shared_fft_bram_array.sv
// Banked BRAM array shared between FFT mode ({re,im} per bank port) and KEY/RNS mode (scalar key/real reads).
// Optional sticky error checking is built when SHARED_FFT_BRAM_ERR_CHECK_EN is defined.
module shared_fft_bram_array #(
    parameter int LOGN         = 13,
    parameter int LOGQ         = 54,
    parameter int FLP_WORDSIZE = 64,
    parameter int BRAM_RD_LAT  = 2,
    parameter int NUM_BANKS    = 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   mode_req_valid,
    input  logic                                   mode_req,
    output logic                                   mode_ack,
    output logic                                   is_fft,
    output logic                                   busy,
    input  logic [NUM_BANKS*(LOGN-$clog2(NUM_BANKS))-1:0] fft_rd_addr,
    input  logic [NUM_BANKS*(LOGN-$clog2(NUM_BANKS))-1:0] fft_wr_addr,
    input  logic [NUM_BANKS*2*FLP_WORDSIZE-1:0]    fft_wr_data,
    input  logic [NUM_BANKS-1:0]                   fft_wea,
    output logic [NUM_BANKS*2*FLP_WORDSIZE-1:0]    fft_rd_data,
    input  logic                                   rns_rd_en,
    input  logic [LOGN-1:0]                        rns_rd_addr,
    output logic                                   rns_rd_valid,
    output logic [FLP_WORDSIZE-1:0]                rns_rd_data,
    input  logic                                   key_rd_en,
    input  logic [LOGN-1:0]                        key_rd_addr,
    output logic                                   key_rd_valid,
    output logic [LOGQ-1:0]                        key_rd_data,
    input  logic                                   key_wea,
    input  logic [LOGN-1:0]                        key_wr_addr,
    input  logic [LOGQ-1:0]                        key_wr_data,
    input  logic                                   err_clr,
    output logic                                   err_collision,
    output logic                                   err_mode
);
    localparam int LB    = $clog2(NUM_BANKS);
    localparam int AW    = LOGN - LB;
    localparam int W     = 2 * FLP_WORDSIZE;
    localparam int DEPTH = 1 << AW;
    localparam int CW    = $clog2(BRAM_RD_LAT + 1);

    typedef enum logic [1:0] {
        ST_KEY          = 2'd0,
        ST_DRAIN_TO_FFT = 2'd1,
        ST_FFT          = 2'd2,
        ST_DRAIN_TO_KEY = 2'd3
    } state_t;

    state_t              state_r;
    logic [CW-1:0]       drain_cnt_r;
    logic [W-1:0]        mem_r      [NUM_BANKS][DEPTH];
    logic [W-1:0]        rd_a_q_r   [NUM_BANKS][BRAM_RD_LAT];
    logic [FLP_WORDSIZE-1:0] rd_b_q_r [NUM_BANKS][BRAM_RD_LAT];
    logic [LB-1:0]       key_bank_q_r [BRAM_RD_LAT];
    logic [LB-1:0]       rns_bank_q_r [BRAM_RD_LAT];
    logic [BRAM_RD_LAT-1:0] key_v_r;
    logic [BRAM_RD_LAT-1:0] rns_v_r;
    logic [AW-1:0]       rd_a_addr_s [NUM_BANKS];

    logic                in_key_s, in_fft_s;
    logic                key_issue_s, rns_issue_s, key_we_s;
    logic [NUM_BANKS-1:0] fft_we_s;

    // Drain states block every write and every new read request.
    assign in_key_s    = (state_r == ST_KEY);
    assign in_fft_s    = (state_r == ST_FFT);
    assign key_issue_s = key_rd_en & in_key_s;
    assign rns_issue_s = rns_rd_en & in_key_s;
    assign key_we_s    = key_wea & in_key_s;
    assign fft_we_s    = fft_wea & {NUM_BANKS{in_fft_s}};

    // Mode FSM: a drain of BRAM_RD_LAT cycles lets in-flight reads retire before the switch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_KEY;
            drain_cnt_r <= {CW{1'b0}};
            is_fft      <= 1'b0;
            busy        <= 1'b0;
            mode_ack    <= 1'b0;
        end else begin
            mode_ack <= 1'b0;
            case (state_r)
                ST_KEY, ST_FFT: begin
                    if (mode_req_valid && (mode_req != in_fft_s)) begin
                        state_r     <= in_fft_s ? ST_DRAIN_TO_KEY : ST_DRAIN_TO_FFT;
                        busy        <= 1'b1;
                        drain_cnt_r <= {CW{1'b0}};
                    end else if (mode_req_valid) begin
                        mode_ack <= 1'b1;
                    end
                end
                ST_DRAIN_TO_FFT, ST_DRAIN_TO_KEY: begin
                    if (drain_cnt_r == CW'(BRAM_RD_LAT - 1)) begin
                        state_r     <= (state_r == ST_DRAIN_TO_FFT) ? ST_FFT : ST_KEY;
                        is_fft      <= (state_r == ST_DRAIN_TO_FFT);
                        busy        <= 1'b0;
                        mode_ack    <= 1'b1;
                        drain_cnt_r <= {CW{1'b0}};
                    end else begin
                        drain_cnt_r <= drain_cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_r <= ST_KEY;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Port A serves FFT reads in FFT mode and key reads otherwise.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (in_fft_s) begin
                rd_a_addr_s[b] = fft_rd_addr[b*AW +: AW];
            end else begin
                rd_a_addr_s[b] = key_rd_addr[LOGN-1:LB];
            end
        end
    end

    // Bank write port; key writes touch only the low LOGQ bits.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (fft_we_s[b]) begin
                mem_r[b][fft_wr_addr[b*AW +: AW]] <= fft_wr_data[b*W +: W];
            end else if (key_we_s && (key_wr_addr[LB-1:0] == LB'(b))) begin
                mem_r[b][key_wr_addr[LOGN-1:LB]][LOGQ-1:0] <= key_wr_data;
            end
        end
    end

    // Read-first data pipelines plus valid and bank-index shift registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                for (int s = 0; s < BRAM_RD_LAT; s++) begin
                    rd_a_q_r[b][s] <= {W{1'b0}};
                    rd_b_q_r[b][s] <= {FLP_WORDSIZE{1'b0}};
                end
            end
            for (int s = 0; s < BRAM_RD_LAT; s++) begin
                key_bank_q_r[s] <= {LB{1'b0}};
                rns_bank_q_r[s] <= {LB{1'b0}};
            end
            key_v_r <= {BRAM_RD_LAT{1'b0}};
            rns_v_r <= {BRAM_RD_LAT{1'b0}};
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                rd_a_q_r[b][0] <= mem_r[b][rd_a_addr_s[b]];
                rd_b_q_r[b][0] <= mem_r[b][rns_rd_addr[LOGN-1:LB]][W-1:FLP_WORDSIZE];
                for (int s = 1; s < BRAM_RD_LAT; s++) begin
                    rd_a_q_r[b][s] <= rd_a_q_r[b][s-1];
                    rd_b_q_r[b][s] <= rd_b_q_r[b][s-1];
                end
            end
            key_bank_q_r[0] <= key_rd_addr[LB-1:0];
            rns_bank_q_r[0] <= rns_rd_addr[LB-1:0];
            key_v_r[0]      <= key_issue_s;
            rns_v_r[0]      <= rns_issue_s;
            for (int s = 1; s < BRAM_RD_LAT; s++) begin
                key_bank_q_r[s] <= key_bank_q_r[s-1];
                rns_bank_q_r[s] <= rns_bank_q_r[s-1];
                key_v_r[s]      <= key_v_r[s-1];
                rns_v_r[s]      <= rns_v_r[s-1];
            end
        end
    end

    for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_fft_out
        assign fft_rd_data[gb*W +: W] = rd_a_q_r[gb][BRAM_RD_LAT-1];
    end

    assign key_rd_valid = key_v_r[BRAM_RD_LAT-1];
    assign rns_rd_valid = rns_v_r[BRAM_RD_LAT-1];
    assign key_rd_data  = rd_a_q_r[key_bank_q_r[BRAM_RD_LAT-1]][BRAM_RD_LAT-1][LOGQ-1:0];
    assign rns_rd_data  = rd_b_q_r[rns_bank_q_r[BRAM_RD_LAT-1]][BRAM_RD_LAT-1];

`ifdef SHARED_FFT_BRAM_ERR_CHECK_EN
    logic coll_s, mode_err_s;

    // Same-bank same-address FFT read/write, and any access issued in the wrong mode.
    always_comb begin
        coll_s = 1'b0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            coll_s = coll_s | (fft_we_s[b] & (fft_rd_addr[b*AW +: AW] == fft_wr_addr[b*AW +: AW]));
        end
        mode_err_s = ((|fft_wea) & ~in_fft_s) | ((key_rd_en | rns_rd_en | key_wea) & ~in_key_s);
    end

    // Sticky flags; a new error in the clearing cycle wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_collision <= 1'b0;
            err_mode      <= 1'b0;
        end else begin
            err_collision <= (err_collision & ~err_clr) | coll_s;
            err_mode      <= (err_mode & ~err_clr) | mode_err_s;
        end
    end
`else
    logic unused_err_clr_s;
    assign unused_err_clr_s = err_clr;
    assign err_collision    = 1'b0;
    assign err_mode         = 1'b0;
`endif

endmodule
